// File: rtl/coprocessor0_pkg.sv
// ---------------------------------------------------------------------------
// coprocessor0_pkg
//   Shared constants for the CP0 system-control block: register numbers,
//   Status/Cause bit positions and ranges, exception codes used for
//   BadVAddr capture, and the Status write mask.
// ---------------------------------------------------------------------------
package coprocessor0_pkg;

    // Value of wb_wb_cp0 that commits an mtc0 write.
    localparam logic REG_WB = 1'b1;

    // CP0 register numbers (5-bit register bus).
    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    // Status fields.
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_IM_HI  = 15;

    // Cause fields.
    localparam int CAUSE_BD         = 31;
    localparam int CAUSE_IP_HW_HI   = 15;
    localparam int CAUSE_IP_HW_LO   = 10;
    localparam int CAUSE_IP_SW_HI   = 9;
    localparam int CAUSE_IP_SW_LO   = 8;
    localparam int CAUSE_EXCCODE_HI = 6;
    localparam int CAUSE_EXCCODE_LO = 2;
    localparam int CAUSE_WP_HI      = 23;
    localparam int CAUSE_WP_LO      = 22;

    // Exception codes that carry a faulting address.
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Status bits an mtc0 may set: [28], IM[15:8], EXL, IE.
    localparam logic [31:0] STATUS_WMASK = 32'h1000_FF03;

endpackage

// File: rtl/coprocessor0_timer.sv
// ---------------------------------------------------------------------------
// coprocessor0_timer
//   Count/Compare timer. Count advances every clock (COUNT_HALF=0) or every
//   second clock (COUNT_HALF=1) and wraps. timer_int is a sticky flag set one
//   cycle after Count==Compare and cleared only by a Compare write.
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   count_we         load write_data into Count, restart the divider
//   compare_we       load write_data into Compare, clear timer_int
//   write_data       mtc0 data
//   count, compare   current register values
//   timer_int        sticky match flag
// ---------------------------------------------------------------------------
module coprocessor0_timer #(
    parameter int DATA_WIDTH = 32,
    parameter int COUNT_HALF = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  count_we,
    input  logic                  compare_we,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] count,
    output logic [DATA_WIDTH-1:0] compare,
    output logic                  timer_int
);

    logic toggle;

    // NOTE: every register here uses non-blocking assignment so all of them
    // see the pre-edge values of each other (the match uses old Count/Compare).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            compare   <= '0;
            toggle    <= 1'b0;
            timer_int <= 1'b0;
        end else begin
            // A Count load overrides this cycle's increment and restarts the divider.
            if (count_we) begin
                count  <= write_data;
                toggle <= 1'b0;
            end else begin
                if (COUNT_HALF == 0 || toggle)
                    count <= count + 1'b1;
                toggle <= (COUNT_HALF != 0) ? ~toggle : 1'b0;
            end

            if (compare_we)
                compare <= write_data;

            // Compare write wins over a simultaneous match.
            if (compare_we)
                timer_int <= 1'b0;
            else if (count == compare)
                timer_int <= 1'b1;
        end
    end

endmodule

// File: rtl/coprocessor0.sv
// ---------------------------------------------------------------------------
// coprocessor0
//   CP0 system-control register file: Status, Cause, EPC, BadVAddr plus the
//   Count/Compare timer. Commits WB-stage mtc0 writes, exception entry and
//   eret exit, samples hardware interrupts and raises interrupt_request.
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   wb_wb_cp0, wb_cp0_write_addr,
//   wb_cp0_write                        mtc0 commit, register number, data
//   cp0_read_addr, cp0_read_data        combinational mfc0 read (unmapped -> 0)
//   exception_valid, exc_code, exc_pc,
//   exc_in_delay_slot, exc_badvaddr     exception commit
//   eret                                exception return commit
//   int_i                               hardware interrupt levels
//   cp0_status, cp0_cause, cp0_epc      register outputs
//   timer_int                           sticky Count==Compare flag
//   interrupt_request                   enabled, pending, not in exception level
// ---------------------------------------------------------------------------
module coprocessor0
    import coprocessor0_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COUNT_HALF = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_wb_cp0,
    input  logic [4:0]            wb_cp0_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_cp0_write,
    input  logic [4:0]            cp0_read_addr,
    output logic [DATA_WIDTH-1:0] cp0_read_data,
    input  logic                  exception_valid,
    input  logic [4:0]            exc_code,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    input  logic                  exc_in_delay_slot,
    input  logic [DATA_WIDTH-1:0] exc_badvaddr,
    input  logic                  eret,
    input  logic [5:0]            int_i,
    output logic [DATA_WIDTH-1:0] cp0_status,
    output logic [DATA_WIDTH-1:0] cp0_cause,
    output logic [DATA_WIDTH-1:0] cp0_epc,
    output logic                  timer_int,
    output logic                  interrupt_request
);

    logic [DATA_WIDTH-1:0] status, cause, epc, badvaddr;
    logic [DATA_WIDTH-1:0] status_n, cause_n, epc_n, badvaddr_n;
    logic [DATA_WIDTH-1:0] count, compare;
    logic                  mtc0;
    logic                  exl;

    assign mtc0 = (wb_wb_cp0 == REG_WB);
    assign exl  = status[STATUS_EXL];

    // Count/Compare writes are independent of exception/eret priority.
    coprocessor0_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .COUNT_HALF (COUNT_HALF)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_we   (mtc0 && wb_cp0_write_addr == CP0_REG_COUNT),
        .compare_we (mtc0 && wb_cp0_write_addr == CP0_REG_COMPARE),
        .write_data (wb_cp0_write),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int)
    );

    // Priority exception > eret > mtc0, applied per field: the lower-priority
    // source only loses the fields the higher-priority one owns.
    always_comb begin
        // NOTE: every next-state variable starts from the held value so no
        // path leaves it unassigned and no latch is inferred.
        status_n   = status;
        cause_n    = cause;
        epc_n      = epc;
        badvaddr_n = badvaddr;

        if (mtc0 && wb_cp0_write_addr == CP0_REG_STATUS)
            status_n = wb_cp0_write & STATUS_WMASK;
        if (mtc0 && wb_cp0_write_addr == CP0_REG_CAUSE) begin
            cause_n[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO] = wb_cp0_write[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO];
            cause_n[CAUSE_WP_HI:CAUSE_WP_LO]       = wb_cp0_write[CAUSE_WP_HI:CAUSE_WP_LO];
        end

        // Hardware pending bits; IP7 shares its line with the timer.
        cause_n[CAUSE_IP_HW_HI:CAUSE_IP_HW_LO] = {int_i[5] | timer_int, int_i[4:0]};

        if (exception_valid) begin
            status_n[STATUS_EXL] = 1'b1;
            cause_n[CAUSE_EXCCODE_HI:CAUSE_EXCCODE_LO] = exc_code;
            // A nested exception keeps the original return point.
            if (!exl) begin
                epc_n = exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
                cause_n[CAUSE_BD] = exc_in_delay_slot;
            end
            if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
                badvaddr_n = exc_badvaddr;
        end else begin
            if (eret)
                status_n[STATUS_EXL] = 1'b0;
            if (mtc0 && wb_cp0_write_addr == CP0_REG_EPC)
                epc_n = wb_cp0_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status   <= '0;
            cause    <= '0;
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            status   <= status_n;
            cause    <= cause_n;
            epc      <= epc_n;
            badvaddr <= badvaddr_n;
        end
    end

    always_comb begin
        cp0_read_data = '0;
        case (cp0_read_addr)
            CP0_REG_BADVADDR: cp0_read_data = badvaddr;
            CP0_REG_COUNT:    cp0_read_data = count;
            CP0_REG_COMPARE:  cp0_read_data = compare;
            CP0_REG_STATUS:   cp0_read_data = status;
            CP0_REG_CAUSE:    cp0_read_data = cause;
            CP0_REG_EPC:      cp0_read_data = epc;
            default:          cp0_read_data = '0;
        endcase
    end

    assign cp0_status = status;
    assign cp0_cause  = cause;
    assign cp0_epc    = epc;

    assign interrupt_request = (|(status[STATUS_IM_HI:STATUS_IM_LO] & cause[15:8]))
                               & status[STATUS_IE] & ~status[STATUS_EXL];

endmodule
